// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: instruction memory request/response channel, decode
// handshake and the pipeline control inputs that steer fetching.
interface instr_fetch_unit_if;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   modport master (
      input  fetch_en, redirect_valid, redirect_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
      output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
   );

   modport slave (
      output fetch_en, redirect_valid, redirect_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
      input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// RISC-V instruction fetch stage: in-order imem requests, a QDEPTH-entry
// instruction queue toward decode, and redirect flushing of stale responses.
module instr_fetch_unit_chk #(
   parameter int QDEPTH = 2
) (
   input logic clk,
   input logic rst_n,
   input logic push_s,
   input logic pop_s,
   input logic full_s
);
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      (push_s && full_s) |-> pop_s);
endmodule

module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input logic               clk,
   input logic               rst_n,
   instr_fetch_unit_if.master fif
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH) + 1;
   localparam logic [CW-1:0] CW_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CW_ONE   = CW'(1'b1);
   localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);
   localparam logic [PW-1:0] PW_ZERO  = {PW{1'b0}};
   localparam logic [PW-1:0] PW_ONE   = PW'(1'b1);

   typedef enum logic [0:0] {FETCH = 1'b0, FLUSH = 1'b1} state_t;

   state_t        state_r, state_n_s;
   logic [31:0]   pc_r, pc_n_s;
   logic [CW-1:0] outstanding_r, outstanding_n_s;
   logic [CW-1:0] count_r, count_n_s;
   logic [CW-1:0] stale_r, stale_n_s;
   logic [CW-1:0] pending_s;
   logic [PW-1:0] head_r, head_n_s, tail_r, tail_n_s;
   logic [31:0]   q_pc_r    [QDEPTH];
   logic [31:0]   q_instr_r [QDEPTH];
   logic [CW:0]   inflight_s;
   logic [31:0]   rsp_pc_s;
   logic          pop_s, push_s, accept_s, req_valid_s;

   // Request issue, credit and queue push/pop qualification.
   always_comb begin
      pop_s = (count_r != CW_ZERO) && fif.if_ready;
      // A head popped this cycle frees its slot, which sustains one fetch per cycle.
      inflight_s  = {1'b0, outstanding_r} + {1'b0, count_r} - {{CW{1'b0}}, pop_s};
      req_valid_s = rst_n && (state_r == FETCH) && fif.fetch_en && !fif.redirect_valid &&
                    (inflight_s < {1'b0, QDEPTH_C});
      accept_s    = req_valid_s && fif.imem_req_ready;
      push_s      = fif.imem_rsp_valid && (state_r == FETCH) && !fif.redirect_valid;
      // The oldest outstanding request was issued outstanding_r words before pc_r.
      rsp_pc_s    = pc_r - {{(30-CW){1'b0}}, outstanding_r, 2'b00};
      pending_s   = outstanding_r + stale_r;
   end

   // Next-state logic for the FETCH/FLUSH controller, PC and queue pointers.
   always_comb begin
      state_n_s       = state_r;
      pc_n_s          = pc_r;
      outstanding_n_s = outstanding_r;
      count_n_s       = count_r;
      stale_n_s       = stale_r;
      head_n_s        = head_r;
      tail_n_s        = tail_r;
      if (fif.redirect_valid) begin
         pc_n_s          = {fif.redirect_pc[31:2], 2'b00};
         outstanding_n_s = CW_ZERO;
         count_n_s       = CW_ZERO;
         head_n_s        = PW_ZERO;
         tail_n_s        = PW_ZERO;
         stale_n_s       = (fif.imem_rsp_valid && (pending_s != CW_ZERO)) ? (pending_s - CW_ONE) : pending_s;
         state_n_s       = (stale_n_s != CW_ZERO) ? FLUSH : FETCH;
      end else begin
         case (state_r)
            FETCH: begin
               pc_n_s          = accept_s ? (pc_r + 32'd4) : pc_r;
               outstanding_n_s = outstanding_r + CW'(accept_s) - CW'(push_s);
               count_n_s       = count_r + CW'(push_s) - CW'(pop_s);
               head_n_s        = pop_s ? (head_r + PW_ONE) : head_r;
               tail_n_s        = push_s ? (tail_r + PW_ONE) : tail_r;
               state_n_s       = FETCH;
            end
            FLUSH: begin
               stale_n_s = (fif.imem_rsp_valid && (stale_r != CW_ZERO)) ? (stale_r - CW_ONE) : stale_r;
               state_n_s = (stale_n_s == CW_ZERO) ? FETCH : FLUSH;
            end
            default: begin
               state_n_s = FETCH;
            end
         endcase
      end
   end

   // Controller, PC and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= FETCH;
         pc_r          <= RESET_PC;
         outstanding_r <= CW_ZERO;
         count_r       <= CW_ZERO;
         stale_r       <= CW_ZERO;
         head_r        <= PW_ZERO;
         tail_r        <= PW_ZERO;
      end else begin
         state_r       <= state_n_s;
         pc_r          <= pc_n_s;
         outstanding_r <= outstanding_n_s;
         count_r       <= count_n_s;
         stale_r       <= stale_n_s;
         head_r        <= head_n_s;
         tail_r        <= tail_n_s;
      end
   end

   // Instruction queue storage, written at the tail on each accepted response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QDEPTH; i++) begin
            q_pc_r[i]    <= 32'h0000_0000;
            q_instr_r[i] <= 32'h0000_0000;
         end
      end else if (push_s) begin
         q_pc_r[tail_r]    <= rsp_pc_s;
         q_instr_r[tail_r] <= fif.imem_rsp_data;
      end else begin
         q_pc_r[tail_r]    <= q_pc_r[tail_r];
         q_instr_r[tail_r] <= q_instr_r[tail_r];
      end
   end

   assign fif.imem_req_valid = req_valid_s;
   assign fif.imem_req_addr  = pc_r;
   assign fif.if_valid       = (count_r != CW_ZERO);
   assign fif.if_pc          = (count_r != CW_ZERO) ? q_pc_r[head_r] : 32'h0000_0000;
   assign fif.if_instr       = (count_r != CW_ZERO) ? q_instr_r[head_r] : 32'h0000_0000;

   instr_fetch_unit_chk #(.QDEPTH(QDEPTH)) u_chk (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_s (push_s),
      .pop_s  (pop_s),
      .full_s (count_r == QDEPTH_C)
   );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized and directed bench for instr_fetch_unit against a queue-based
// model of fetch, memory and decode.
module tb_instr_fetch_unit;
   localparam int          QDEPTH   = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   instr_fetch_unit_if fif();

   instr_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fif   (fif)
   );

   always #5 clk = ~clk;

   logic [31:0] m_pc;
   int          m_stale;
   logic [31:0] memq [$];
   ent_t        decq [$];
   int          n_total = 0;
   int          n_pass = 0;
   logic        obs_rv, obs_iv;
   logic [31:0] obs_addr, obs_pc, obs_instr;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_pc    = RESET_PC;
      m_stale = 0;
      memq.delete();
      decq.delete();
   endtask

   // One clock: drive inputs, compare against the model, advance the model.
   task automatic cycle(input bit rst, input bit fe, input bit ir, input bit rr,
                        input bit rsp_en, input bit rd, input logic [31:0] rpc);
      bit          exp_rv, pop, rsp;
      int          live;
      logic [31:0] a;
      @(negedge clk);
      rst_n = rst;
      if (!rst) model_reset();
      rsp = rst && rsp_en && (memq.size() > 0);
      fif.fetch_en       = fe;
      fif.if_ready       = ir;
      fif.imem_req_ready = rr;
      fif.redirect_valid = rd;
      fif.redirect_pc    = rpc;
      fif.imem_rsp_valid = rsp;
      fif.imem_rsp_data  = rsp ? mem_data(memq[0]) : 32'hDEAD_BEEF;
      #1;
      pop    = (decq.size() > 0) && ir;
      live   = memq.size() - m_stale;
      exp_rv = rst && (m_stale == 0) && fe && !rd &&
               ((live + decq.size() - (pop ? 1 : 0)) < QDEPTH);
      obs_rv = fif.imem_req_valid; obs_addr = fif.imem_req_addr;
      obs_iv = fif.if_valid; obs_pc = fif.if_pc; obs_instr = fif.if_instr;
      check32("req_valid", {31'h0, obs_rv}, {31'h0, exp_rv});
      if (exp_rv) check32("req_addr", obs_addr, m_pc);
      check32("if_valid", {31'h0, obs_iv}, {31'h0, decq.size() > 0});
      if (decq.size() > 0) begin
         check32("if_pc", obs_pc, decq[0].pc);
         check32("if_instr", obs_instr, decq[0].instr);
      end
      if (rst) begin
         if (pop) void'(decq.pop_front());
         if (rsp) begin
            a = memq.pop_front();
            if (m_stale > 0) m_stale--;
            else if (!rd) decq.push_back({a, mem_data(a)});
         end
         if (rd) begin
            decq.delete();
            m_stale = memq.size();
            m_pc    = {rpc[31:2], 2'b00};
         end else if (exp_rv && rr) begin
            memq.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
         done = (memq.size() == 0) && (decq.size() == 0) && (m_stale == 0);
      end
      check32("drain_bound", {31'h0, done}, 32'h1);
   endtask

   initial begin
      int nreq;
      fif.fetch_en = 1'b0; fif.if_ready = 1'b0; fif.imem_req_ready = 1'b0;
      fif.redirect_valid = 1'b0; fif.redirect_pc = 32'h0;
      fif.imem_rsp_valid = 1'b0; fif.imem_rsp_data = 32'h0;
      model_reset();

      // Reset state with fetch_en already high.
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check32("rst_req_valid", {31'h0, obs_rv}, 32'h0);
      check32("rst_if_valid", {31'h0, obs_iv}, 32'h0);
      check32("rst_if_pc", obs_pc, 32'h0);
      check32("rst_if_instr", obs_instr, 32'h0);

      // Streaming at one instruction per cycle.
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
         if (i < 4) check32("stream_addr", obs_addr, 32'(i) * 32'd4);
         if (i == 1) check32("stream_fill", {31'h0, obs_iv}, 32'h0);
         if (i == 2) check32("stream_first_instr", obs_instr, mem_data(32'h0));
         if (i >= 2) check32("stream_if_pc", obs_pc, 32'(i - 2) * 32'd4);
         check32("stream_b2b", {31'h0, obs_rv}, 32'h1);
      end
      drain();

      // Decode stalled: exactly QDEPTH requests, then resume at 0x8.
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      nreq = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         nreq += int'(obs_rv);
      end
      check32("stall_nreq", 32'(nreq), 32'd2);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check32("resume_valid", {31'h0, obs_rv}, 32'h1);
      check32("resume_addr", obs_addr, 32'h0000_0008);
      drain();

      // Redirect with two requests outstanding.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      check32("two_outstanding", {31'h0, obs_rv}, 32'h0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
         check32("flush_no_req", {31'h0, obs_rv}, 32'h0);
         check32("flush_no_if", {31'h0, obs_iv}, 32'h0);
      end
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check32("post_flush_valid", {31'h0, obs_rv}, 32'h1);
      check32("post_flush_addr", obs_addr, 32'h0000_0100);
      drain();

      // Redirect coinciding with a response and a decode handshake.
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
      check32("rd_hs_if_valid", {31'h0, obs_iv}, 32'h1);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check32("rd_hs_empty", {31'h0, obs_iv}, 32'h0);
      check32("rd_target_addr", obs_addr, 32'h0000_0200);
      drain();

      // PC wraps modulo 2^32.
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
         check32("wrap_valid", {31'h0, obs_rv}, 32'h1);
         check32("wrap_addr", obs_addr, 32'hFFFF_FFF8 + 32'(i) * 32'd4);
      end
      drain();

      // Asynchronous reset in the middle of a stream.
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check32("midrst_if_valid", {31'h0, obs_iv}, 32'h0);
      check32("midrst_req_valid", {31'h0, obs_rv}, 32'h0);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check32("midrst_first_addr", obs_addr, RESET_PC);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         cycle(1'b1,
               $urandom_range(99) < 80,
               $urandom_range(99) < 70,
               $urandom_range(99) < 70,
               $urandom_range(99) < 60,
               $urandom_range(99) < 4,
               $urandom);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
